game_menu_fsm: RTL and testbench
================================

Name: game_menu_fsm

Overview:
- Consumes the single-cycle, debounced button pulses produced by the arcade's debounce/one-pulse front end. Drives game selection on the Basys3.
- Runs the top-level arcade flow: attract screen, game menu, confirm, play.
- Outputs the selected/active game index, a game-enable level, a one-cycle start strobe, and selection LEDs to the game cores and display logic.

Parameters:
- NUM_GAMES, 4: number of selectable games. Legal range is 2..2^IDX_W.
- IDX_W, 2: width of the game index.
- TIMEOUT_CYCLES, 1000000000: idle cycles before menu/confirm fall back. Default is 10 s at 100 MHz.
- TO_W, 30: width of the idle counter. Must hold TIMEOUT_CYCLES-1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
- btn_up_p  input  1  one-cycle pulse, menu up.
- btn_down_p  input  1  one-cycle pulse, menu down.
- btn_sel_p  input  1  one-cycle pulse, select/confirm.
- btn_back_p  input  1  one-cycle pulse, back/abort.
- game_over  input  1  level from the active game core; high when the game has ended.
- sel_idx  output  IDX_W  currently highlighted game.
- active_game  output  IDX_W  game latched at start.
- game_en  output  1  high while in PLAYING.
- start_pulse  output  1  one-cycle strobe on entry to PLAYING.
- state_out  output  2  encoding: ATTRACT=0, MENU=1, CONFIRM=2, PLAYING=3.
- led_onehot  output  NUM_GAMES  selection indicator.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=ATTRACT; sel_idx=0; active_game=0; game_en=0; start_pulse=0; idle counter=0.
  - Reset applied mid-game aborts immediately with the same values.
- All outputs are registered. An input pulse sampled at edge N is reflected in outputs after edge N; latency is 1 cycle.
- Priority when pulses coincide: back > sel > up/down. Simultaneous up and down cause no index change. Exactly one action is taken per cycle.
- ATTRACT:
  - Any pulse (up/down/sel/back) moves to MENU.
  - The pulse is consumed: sel_idx is unchanged.
  - game_over is ignored.
- MENU:
  - up: sel_idx+1, wrapping NUM_GAMES-1 -> 0.
  - down: sel_idx-1, wrapping 0 -> NUM_GAMES-1.
  - sel: move to CONFIRM.
  - back: move to ATTRACT.
  - sel_idx is retained across every state change except reset.
- CONFIRM:
  - sel: move to PLAYING; active_game<=sel_idx; start_pulse=1 for exactly the first cycle state_out=3.
  - back: move to MENU.
  - up/down are ignored.
- PLAYING:
  - game_en=1.
  - game_over=1 moves to MENU; game_en drops on the same edge.
  - back aborts to MENU (back has priority over game_over; the result is identical).
  - up/down/sel are ignored; those buttons belong to the game core.
  - game_over is ignored in all other states.
- Idle counter:
  - Active in MENU and CONFIRM only; increments every cycle with no pulse.
  - Clears on any pulse, any state change, and in ATTRACT/PLAYING.
  - When it reaches TIMEOUT_CYCLES-1 with no pulse: MENU -> ATTRACT, CONFIRM -> MENU; the counter clears.
  - A pulse arriving in that same cycle wins and the timeout is discarded.
- led_onehot:
  - MENU/CONFIRM: 1<<sel_idx.
  - PLAYING: 1<<active_game.
  - ATTRACT: all zeros.
- start_pulse is never high for two consecutive cycles.
- game_en is never high outside PLAYING.

Test Plan:
1. Reset, then btn_up_p at cycle 5 -> state_out=1, sel_idx=0. Then 3 up pulses -> sel_idx=3, led_onehot=4'b1000. One more up -> sel_idx=0 (wrap).
2. In MENU with sel_idx=0, one down pulse -> sel_idx=3 (wrap). Then up and down pulsed in the same cycle -> sel_idx stays 3.
3. Up to sel_idx=2, then sel, sel -> state_out=3, active_game=2, game_en=1, start_pulse high exactly 1 cycle. Raise game_over -> next cycle state_out=1, game_en=0, sel_idx=2.
4. With TIMEOUT_CYCLES=16:
   - Idle in MENU for 16 cycles -> state_out=0.
   - In CONFIRM, 15 idle cycles then an up pulse -> the pulse is ignored, the counter clears, and state stays 2.
   - 16 further idle cycles -> state_out=1.
5. In PLAYING, pulse sel and back in the same cycle -> state_out=1, no new start_pulse. In CONFIRM, pulse sel and back together -> state_out=1 (back wins).
6. Drive rst_n=0 for 1 cycle while in PLAYING with active_game=3 -> next cycle all outputs at reset values and state_out=0.

Source files
------------

// File: rtl/game_menu_fsm.sv
// Top-level arcade flow controller: attract screen, game menu, confirm, play.
// All outputs are registered and reflect button pulses one cycle after they are sampled.
module game_menu_fsm #(
    parameter int unsigned NUM_GAMES      = 4,
    parameter int unsigned IDX_W          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000000000,
    parameter int unsigned TO_W           = 30
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_up_p,
    input  logic                 btn_down_p,
    input  logic                 btn_sel_p,
    input  logic                 btn_back_p,
    input  logic                 game_over,
    output logic [IDX_W-1:0]     sel_idx,
    output logic [IDX_W-1:0]     active_game,
    output logic                 game_en,
    output logic                 start_pulse,
    output logic [1:0]           state_out,
    output logic [NUM_GAMES-1:0] led_onehot
);

    typedef enum logic [1:0] {
        StAttract = 2'd0,
        StMenu    = 2'd1,
        StConfirm = 2'd2,
        StPlaying = 2'd3
    } state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_GAMES - 1);
    localparam logic [TO_W-1:0]  IdleMax = TO_W'(TIMEOUT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic [IDX_W-1:0]     act_q, act_d;
    logic [TO_W-1:0]      idle_q, idle_d;
    logic                 start_q, start_d;
    logic                 en_q;
    logic [NUM_GAMES-1:0] led_q, led_d;
    logic                 any_pulse;
    logic                 timeout;

    assign any_pulse = btn_up_p | btn_down_p | btn_sel_p | btn_back_p;
    assign timeout   = (idle_q == IdleMax) && !any_pulse;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        act_d   = act_q;
        start_d = 1'b0;
        // The idle counter clears unless explicitly advanced below.
        idle_d  = '0;
        unique case (state_q)
            StAttract: begin
                if (any_pulse) state_d = StMenu;
            end
            StMenu: begin
                if (btn_back_p) begin
                    state_d = StAttract;
                end else if (btn_sel_p) begin
                    state_d = StConfirm;
                end else if (btn_up_p && !btn_down_p) begin
                    sel_d = (sel_q == LastIdx) ? '0 : sel_q + IDX_W'(1);
                end else if (btn_down_p && !btn_up_p) begin
                    sel_d = (sel_q == '0) ? LastIdx : sel_q - IDX_W'(1);
                end else if (timeout) begin
                    state_d = StAttract;
                end else if (!any_pulse) begin
                    idle_d = idle_q + TO_W'(1);
                end
            end
            StConfirm: begin
                if (btn_back_p) begin
                    state_d = StMenu;
                end else if (btn_sel_p) begin
                    state_d = StPlaying;
                    act_d   = sel_q;
                    start_d = 1'b1;
                end else if (timeout) begin
                    state_d = StMenu;
                end else if (!any_pulse) begin
                    idle_d = idle_q + TO_W'(1);
                end
            end
            StPlaying: begin
                if (btn_back_p || game_over) state_d = StMenu;
            end
            default: state_d = StAttract;
        endcase

        unique case (state_d)
            StAttract: led_d = '0;
            StPlaying: led_d = NUM_GAMES'(1) << act_d;
            default:   led_d = NUM_GAMES'(1) << sel_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StAttract;
            sel_q   <= '0;
            act_q   <= '0;
            idle_q  <= '0;
            start_q <= 1'b0;
            en_q    <= 1'b0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            act_q   <= act_d;
            idle_q  <= idle_d;
            start_q <= start_d;
            en_q    <= (state_d == StPlaying);
            led_q   <= led_d;
        end
    end

    assign sel_idx     = sel_q;
    assign active_game = act_q;
    assign game_en     = en_q;
    assign start_pulse = start_q;
    assign state_out   = state_q;
    assign led_onehot  = led_q;

endmodule

// File: tb/tb_game_menu_fsm.sv
// Bench for game_menu_fsm: directed flow scenarios then random pulses, scored against
// an arithmetic reference model through an expected-output queue.
module tb_game_menu_fsm;

    localparam int NG = 4;
    localparam int IW = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          up = 1'b0, down = 1'b0, sel = 1'b0, back = 1'b0, go = 1'b0;
    logic [IW-1:0] sel_idx, active_game;
    logic          game_en, start_pulse;
    logic [1:0]    state_out;
    logic [NG-1:0] led_onehot;

    typedef struct {
        int st;
        int sel;
        int act;
        int en;
        int start;
        int led;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state: plain integers, MENU/CONFIRM fall back by one state number.
    int m_st = 0, m_sel = 0, m_act = 0, m_idle = 0;

    game_menu_fsm #(
        .NUM_GAMES      (NG),
        .IDX_W          (IW),
        .TIMEOUT_CYCLES (TO),
        .TO_W           (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_up_p    (up),
        .btn_down_p  (down),
        .btn_sel_p   (sel),
        .btn_back_p  (back),
        .game_over   (go),
        .sel_idx     (sel_idx),
        .active_game (active_game),
        .game_en     (game_en),
        .start_pulse (start_pulse),
        .state_out   (state_out),
        .led_onehot  (led_onehot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input bit u, input bit d, input bit s, input bit b,
                                   input bit g, input bit rst);
        exp_t e;
        bit   anyp = u | d | s | b;
        int   start = 0;
        if (rst) begin
            m_st = 0; m_sel = 0; m_act = 0; m_idle = 0;
        end else if (m_st == 0) begin
            if (anyp) m_st = 1;
            m_idle = 0;
        end else if (m_st == 3) begin
            if (b || g) m_st = 1;
            m_idle = 0;
        end else if (!anyp) begin
            if (m_idle == TO - 1) begin
                m_st = m_st - 1;
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end else begin
            m_idle = 0;
            if (b) m_st = m_st - 1;
            else if (s) begin
                if (m_st == 2) begin
                    m_act = m_sel;
                    start = 1;
                end
                m_st = m_st + 1;
            end else if (m_st == 1 && u && !d) m_sel = (m_sel + 1) % NG;
            else if (m_st == 1 && d && !u) m_sel = (m_sel + NG - 1) % NG;
        end
        e.st    = m_st;
        e.sel   = m_sel;
        e.act   = m_act;
        e.en    = (m_st == 3) ? 1 : 0;
        e.start = start;
        e.led   = (m_st == 0) ? 0 : (1 << ((m_st == 3) ? m_act : m_sel));
        return e;
    endfunction

    task automatic step(input bit u = 0, input bit d = 0, input bit s = 0, input bit b = 0,
                        input bit g = 0, input bit rst = 0);
        @(negedge clk);
        up = u; down = d; sel = s; back = b; go = g; rst_n = ~rst;
        exp_q.push_back(model(u, d, s, b, g, rst));
    endtask

    task automatic idle(input int n, input bit g = 0);
        for (int i = 0; i < n; i++) step(.g(g));
    endtask

    // Monitor: one registered output set per clock; pop and score it.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state_out", int'(state_out), e.st);
            chk("sel_idx", int'(sel_idx), e.sel);
            chk("active_game", int'(active_game), e.act);
            chk("game_en", int'(game_en), e.en);
            chk("start_pulse", int'(start_pulse), e.start);
            chk("led_onehot", int'(led_onehot), e.led);
        end
    end

    initial begin
        // Reset, then up pulse in cycle 5 enters MENU without moving the index.
        step(.rst(1)); step(.rst(1));
        idle(2);
        step(.u(1));
        step(.u(1)); step(.u(1)); step(.u(1));
        step(.u(1));
        // Down wraps 0 -> 3; simultaneous up/down is a no-op.
        step(.d(1));
        step(.u(1), .d(1));
        // Select game 2, play, then game_over returns to MENU.
        step(.u(1)); step(.u(1)); step(.u(1));
        step(.s(1)); step(.s(1));
        idle(2);
        step(.g(1)); step(.g(1));
        // MENU idle timeout, then CONFIRM timeout with a late pulse discarding it.
        idle(16);
        step(.u(1)); step(.s(1));
        idle(15);
        step(.u(1));
        idle(16);
        // sel+back together in PLAYING and in CONFIRM both land in MENU.
        step(.s(1)); step(.s(1));
        step(.s(1), .b(1));
        step(.s(1));
        step(.s(1), .b(1));
        // Reset mid-game with active_game=3.
        step(.u(1)); step(.s(1)); step(.s(1)); idle(1);
        step(.rst(1));
        idle(2);
        // Random phase: busy bursts alternate with quiet stretches long enough to time out.
        for (int seg = 0; seg < 150; seg++) begin
            if ($urandom_range(0, 2) == 0) begin
                idle($urandom_range(10, 20), 1'($urandom_range(0, 3) == 0));
            end else begin
                for (int i = 0; i < 10; i++) begin
                    step(.u($urandom_range(0, 5) == 0), .d($urandom_range(0, 5) == 0),
                         .s($urandom_range(0, 4) == 0), .b($urandom_range(0, 7) == 0),
                         .g($urandom_range(0, 3) == 0), .rst($urandom_range(0, 199) == 0));
                end
            end
        end
        @(negedge clk);
        up = 0; down = 0; sel = 0; back = 0; go = 0; rst_n = 1;
        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
